// File: rtl/ram_request_arbiter.sv
// ram_request_arbiter: round-robin front end for a single RAM controller.
// Two requesters (port 0 = fetch, port 1 = load/store) share one controller.
// One access or refresh is in flight at a time. Refresh debt is collected by a
// free-running interval timer and is serviced ahead of new accesses.
module ram_request_arbiter #(
    parameter int ADDR_W           = 64,
    parameter int DATA_W           = 64,
    parameter int REFRESH_INTERVAL = 7800,
    parameter int REFRESH_CYCLES   = 8,
    parameter int TIMEOUT          = 255
) (
    input  logic              clock,
    input  logic              resetin,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_error,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_error,
    output logic              ctrl_read,
    output logic              ctrl_write,
    output logic [ADDR_W-1:0] ctrl_address,
    output logic [DATA_W-1:0] ctrl_datain,
    input  logic [DATA_W-1:0] ctrl_dataout,
    input  logic              ctrl_done,
    output logic              ctrl_refresh,
    output logic              refresh_overrun,
    output logic              busy
);

    localparam int RT_W = $clog2(REFRESH_INTERVAL);
    localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        REFRESH
    } state_t;

    state_t            state;
    logic [RT_W-1:0]   refresh_timer;
    logic [3:0]        refresh_debt;
    logic [RC_W-1:0]   refresh_count;
    logic [TO_W-1:0]   wait_count;
    logic              last_grant;
    logic              active_port;
    logic [1:0]        ready_pulse;
    logic [1:0]        done_pulse;
    logic [1:0]        error_pulse;

    logic              refresh_tick;
    logic              refresh_finish;
    logic              timed_out;
    logic              any_valid;
    logic              grant_port;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_data;

    assign refresh_tick   = (refresh_timer == '0);
    assign refresh_finish = (state == REFRESH) && (refresh_count == RC_W'(REFRESH_CYCLES - 1));
    assign timed_out      = (wait_count == TO_W'(TIMEOUT - 1));

    // With both ports asking, the one not served last time wins; otherwise whoever asks.
    assign any_valid   = req0_valid | req1_valid;
    assign grant_port  = req0_valid ? (req1_valid ? ~last_grant : 1'b0) : 1'b1;
    assign sel_write   = grant_port ? req1_write   : req0_write;
    assign sel_address = grant_port ? req1_address : req0_address;
    assign sel_data    = grant_port ? req1_data    : req0_data;

    assign req0_ready = ready_pulse[0];
    assign req1_ready = ready_pulse[1];
    assign req0_done  = done_pulse[0];
    assign req1_done  = done_pulse[1];
    assign req0_error = error_pulse[0];
    assign req1_error = error_pulse[1];
    assign busy       = (state != IDLE);

    // Free-running refresh interval timer, independent of the access state machine.
    always_ff @(posedge clock or negedge resetin) begin
        if (!resetin) begin
            refresh_timer <= RT_W'(REFRESH_INTERVAL - 1);
        end else if (refresh_tick) begin
            refresh_timer <= RT_W'(REFRESH_INTERVAL - 1);
        end else begin
            refresh_timer <= refresh_timer - 1'b1;
        end
    end

    // Refresh debt: grows on each timer expiry, shrinks when a refresh finishes, saturates at 8.
    always_ff @(posedge clock or negedge resetin) begin
        if (!resetin) begin
            refresh_debt    <= '0;
            refresh_overrun <= 1'b0;
        end else if (refresh_tick && !refresh_finish) begin
            if (refresh_debt == 4'd8) begin
                refresh_overrun <= 1'b1;
            end else begin
                refresh_debt <= refresh_debt + 1'b1;
            end
        end else if (!refresh_tick && refresh_finish) begin
            refresh_debt <= refresh_debt - 1'b1;
        end
    end

    // Access/refresh state machine; every command and handshake output is registered here.
    always_ff @(posedge clock or negedge resetin) begin
        if (!resetin) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            active_port   <= 1'b0;
            ctrl_read     <= 1'b0;
            ctrl_write    <= 1'b0;
            ctrl_refresh  <= 1'b0;
            ctrl_address  <= '0;
            ctrl_datain   <= '0;
            ready_pulse   <= '0;
            done_pulse    <= '0;
            error_pulse   <= '0;
            req0_rdata    <= '0;
            req1_rdata    <= '0;
            wait_count    <= '0;
            refresh_count <= '0;
        end else begin
            ready_pulse <= '0;
            done_pulse  <= '0;
            error_pulse <= '0;
            case (state)
                IDLE: begin
                    if (refresh_debt != '0) begin
                        state         <= REFRESH;
                        ctrl_refresh  <= 1'b1;
                        refresh_count <= '0;
                    end else if (any_valid) begin
                        state                   <= ISSUE;
                        active_port             <= grant_port;
                        last_grant              <= grant_port;
                        ready_pulse[grant_port] <= 1'b1;
                        ctrl_read               <= ~sel_write;
                        ctrl_write              <= sel_write;
                        ctrl_address            <= sel_address;
                        ctrl_datain             <= sel_data;
                        wait_count              <= '0;
                    end
                end
                ISSUE: begin
                    if (ctrl_done) begin
                        state                   <= IDLE;
                        ctrl_read               <= 1'b0;
                        ctrl_write              <= 1'b0;
                        done_pulse[active_port] <= 1'b1;
                        if (ctrl_read) begin
                            if (active_port) begin
                                req1_rdata <= ctrl_dataout;
                            end else begin
                                req0_rdata <= ctrl_dataout;
                            end
                        end
                    end else if (timed_out) begin
                        state                    <= IDLE;
                        ctrl_read                <= 1'b0;
                        ctrl_write               <= 1'b0;
                        done_pulse[active_port]  <= 1'b1;
                        error_pulse[active_port] <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                REFRESH: begin
                    if (refresh_finish) begin
                        state        <= IDLE;
                        ctrl_refresh <= 1'b0;
                    end else begin
                        refresh_count <= refresh_count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_request_arbiter.sv
// tb_ram_request_arbiter: scoreboard bench for ram_request_arbiter.
// A bench-side controller model answers commands after a chosen latency (0 = never,
// forcing a timeout). Expected completions are queued at grant and popped at done.
module tb_ram_request_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RI = 20;
    localparam int RC = 8;
    localparam int TO = 200;

    logic          clock = 1'b0;
    logic          resetin = 1'b0;
    logic          req_valid   [2];
    logic          req_write   [2];
    logic [AW-1:0] req_address [2];
    logic [DW-1:0] req_data    [2];
    logic          req_ready   [2];
    logic          req_done    [2];
    logic          req_error   [2];
    logic [DW-1:0] req_rdata   [2];
    logic          ctrl_read, ctrl_write, ctrl_refresh, ctrl_done;
    logic          refresh_overrun, busy;
    logic [AW-1:0] ctrl_address;
    logic [DW-1:0] ctrl_datain, ctrl_dataout;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            dlat;
        int            t0;
    } exp_t;

    exp_t          sb0 [$];
    exp_t          sb1 [$];
    exp_t          inflight;
    int            grant_log [$];
    logic [DW-1:0] model_rdata [2];
    int            ctrl_latency = 3;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            release_cyc = 0;
    int            first_ref_cyc = -1;
    int            refresh_done_count = 0;
    int            cmd_cycles = 0;
    int            ref_run = 0;
    logic          prev_refresh = 1'b0;
    logic          prev_busy = 1'b0;
    logic [AW-1:0] held_addr = '0;

    ram_request_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .REFRESH_INTERVAL(RI),
        .REFRESH_CYCLES(RC), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .resetin(resetin),
        .req0_valid(req_valid[0]), .req0_write(req_write[0]),
        .req0_address(req_address[0]), .req0_data(req_data[0]),
        .req0_ready(req_ready[0]), .req0_done(req_done[0]),
        .req0_rdata(req_rdata[0]), .req0_error(req_error[0]),
        .req1_valid(req_valid[1]), .req1_write(req_write[1]),
        .req1_address(req_address[1]), .req1_data(req_data[1]),
        .req1_ready(req_ready[1]), .req1_done(req_done[1]),
        .req1_rdata(req_rdata[1]), .req1_error(req_error[1]),
        .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
        .ctrl_address(ctrl_address), .ctrl_datain(ctrl_datain),
        .ctrl_dataout(ctrl_dataout), .ctrl_done(ctrl_done),
        .ctrl_refresh(ctrl_refresh), .refresh_overrun(refresh_overrun),
        .busy(busy)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Controller read data is a fixed function of the address.
    function automatic logic [DW-1:0] rdfun(input logic [AW-1:0] a);
        return a ^ 16'hDEED;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pops the expectation for a finished access on port p and compares it.
    task automatic handleDone(input int p);
        exp_t e;
        if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            checkOutput($sformatf("done_unexpected%0d", p), req_done[p], 1'b0);
        end else begin
            e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
            checkOutput($sformatf("rdata%0d", p), req_rdata[p], e.rdata);
            checkOutput($sformatf("error%0d", p), req_error[p], e.err);
            checkOutput($sformatf("done_latency%0d", p), cyc - e.t0, e.dlat);
        end
    endtask

    // Builds the expected completion for a request the DUT just accepted.
    task automatic recordGrant(input int p);
        exp_t e;
        e.write = req_write[p];
        e.addr  = req_address[p];
        e.data  = req_data[p];
        e.lat   = ctrl_latency;
        e.t0    = cyc;
        if (ctrl_latency == 0) begin
            e.err   = 1'b1;
            e.dlat  = TO;
            e.rdata = model_rdata[p];
        end else begin
            e.err   = 1'b0;
            e.dlat  = ctrl_latency;
            e.rdata = e.write ? model_rdata[p] : rdfun(e.addr);
            model_rdata[p] = e.rdata;
        end
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        grant_log.push_back(p);
        inflight = e;
    endtask

    // Monitor and controller model, evaluated once per cycle on the falling edge.
    initial begin
        ctrl_done    = 1'b0;
        ctrl_dataout = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (resetin !== 1'b1) begin
                cmd_cycles   = 0;
                ref_run      = 0;
                prev_refresh = 1'b0;
                prev_busy    = 1'b0;
                ctrl_done    = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (req_done[p] === 1'b1) handleDone(p);
                    else if (req_error[p] === 1'b1) checkOutput("error_alone", req_error[p], 1'b0);
                end
                if (req_ready[0] === 1'b1 || req_ready[1] === 1'b1) begin
                    checkOutput("one_ready", req_ready[0] & req_ready[1], 1'b0);
                    recordGrant(req_ready[1] === 1'b1 ? 1 : 0);
                end
                checkOutput("one_cmd", (int'(ctrl_read) + int'(ctrl_write) + int'(ctrl_refresh)) <= 1, 1'b1);
                checkOutput("busy", busy, ctrl_read | ctrl_write | ctrl_refresh);
                if (ctrl_read || ctrl_write) begin
                    cmd_cycles++;
                    if (cmd_cycles == 1) begin
                        checkOutput("cmd_write", ctrl_write, inflight.write);
                        checkOutput("cmd_addr", ctrl_address, inflight.addr);
                        if (inflight.write) checkOutput("cmd_datain", ctrl_datain, inflight.data);
                    end else begin
                        checkOutput("addr_stable", ctrl_address, held_addr);
                    end
                    held_addr = ctrl_address;
                    ctrl_done = (inflight.lat != 0) && (cmd_cycles == inflight.lat);
                end else begin
                    cmd_cycles = 0;
                    ctrl_done  = 1'b0;
                end
                if (ctrl_refresh) begin
                    if (!prev_refresh) begin
                        checkOutput("refresh_from_idle", prev_busy, 1'b0);
                        if (first_ref_cyc < 0) first_ref_cyc = cyc;
                    end
                    ref_run++;
                end else if (prev_refresh) begin
                    checkOutput("refresh_len", ref_run, RC);
                    refresh_done_count++;
                    ref_run = 0;
                end
                prev_refresh = ctrl_refresh;
                prev_busy    = busy;
            end
            ctrl_dataout = rdfun(ctrl_address);
        end
    end

    // Raises a request on port p and holds it until accepted, within a cycle budget.
    task automatic applyStimulus(input int p, input logic wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
        bit got = 1'b0;
        req_write[p]   = wr;
        req_address[p] = a;
        req_data[p]    = d;
        req_valid[p]   = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clock);
            #1;
            if (req_ready[p] === 1'b1) got = 1'b1;
        end
        req_valid[p] = 1'b0;
        if (!got) checkOutput($sformatf("ready_timeout%0d", p), got, 1'b1);
    endtask

    // Waits for every outstanding access to complete, within a cycle budget.
    task automatic waitDrain();
        bit drained = 1'b0;
        for (int i = 0; i < 1000 && !drained; i++) begin
            if (sb0.size() == 0 && sb1.size() == 0) drained = 1'b1;
            else begin
                @(negedge clock);
                #1;
            end
        end
        if (!drained) checkOutput("drain_timeout", drained, 1'b1);
    endtask

    // Asserts reset mid-cycle, checks every output clears at once, then releases.
    task automatic doReset();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clock);
        #1;
        resetin = 1'b0;
        #1;
        checkOutput("reset_ctrl", {ctrl_read, ctrl_write, ctrl_refresh, refresh_overrun, busy}, '0);
        checkOutput("reset_req", {req_ready[0], req_ready[1], req_done[0], req_done[1],
                                  req_error[0], req_error[1]}, '0);
        checkOutput("reset_addr", ctrl_address, '0);
        checkOutput("reset_datain", ctrl_datain, '0);
        checkOutput("reset_rdata", {req_rdata[0], req_rdata[1]}, '0);
        sb0.delete();
        sb1.delete();
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        repeat (2) @(negedge clock);
        #1;
        resetin       = 1'b1;
        release_cyc   = cyc;
        first_ref_cyc = -1;
    endtask

    // Stop a runaway simulation with a reported failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int c0;
        int start;
        int n;
        for (int p = 0; p < 2; p++) begin
            req_valid[p]   = 1'b0;
            req_write[p]   = 1'b0;
            req_address[p] = '0;
            req_data[p]    = '0;
            model_rdata[p] = '0;
        end

        $display("[TB] reset and single read");
        doReset();
        grant_log.delete();
        ctrl_latency = 3;
        applyStimulus(0, 1'b0, 16'h0040, 16'h0000);
        waitDrain();
        checkOutput("t1_rdata", req_rdata[0], 16'hDEAD);
        checkOutput("t1_grants", grant_log.size(), 1);
        repeat (RI + 4) @(negedge clock);
        #1;
        checkOutput("t1_first_refresh", first_ref_cyc - release_cyc, RI + 1);

        $display("[TB] round robin with both ports valid");
        doReset();
        grant_log.delete();
        ctrl_latency = 2;
        fork
            begin
                applyStimulus(0, 1'b0, 16'h0100, 16'h0000);
                applyStimulus(0, 1'b1, 16'h0104, 16'h1111);
            end
            begin
                applyStimulus(1, 1'b1, 16'h0200, 16'h2222);
                applyStimulus(1, 1'b0, 16'h0204, 16'h0000);
            end
        join
        waitDrain();
        checkOutput("t2_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_grant%0d", i), grant_log[i], i % 2);

        $display("[TB] refresh under constant load");
        doReset();
        ctrl_latency = 3;
        c0    = refresh_done_count;
        start = cyc;
        n     = 0;
        while (cyc - start < 200) begin
            applyStimulus(n % 2, (n % 3) == 0, AW'(16'h1000 + n * 4), DW'(16'h5000 + n));
            n++;
        end
        waitDrain();
        repeat (20) @(negedge clock);
        #1;
        checkOutput("t3_refreshes", (refresh_done_count - c0) >= 8, 1'b1);
        checkOutput("t3_overrun", refresh_overrun, 1'b0);

        $display("[TB] timeout and refresh debt saturation");
        doReset();
        ctrl_latency = 0;
        applyStimulus(1, 1'b0, 16'h0300, 16'h0000);
        ctrl_latency = 2;
        c0 = refresh_done_count;
        applyStimulus(0, 1'b1, 16'h0400, 16'h4444);
        checkOutput("t5_refresh_burst", (refresh_done_count - c0) >= 8, 1'b1);
        checkOutput("t5_overrun", refresh_overrun, 1'b1);
        waitDrain();
        checkOutput("t5_overrun_sticky", refresh_overrun, 1'b1);

        $display("[TB] reset during an access");
        doReset();
        ctrl_latency = 0;
        applyStimulus(1, 1'b0, 16'h0500, 16'h0000);
        repeat (5) @(negedge clock);
        #1;
        checkOutput("t6_busy_before", busy, 1'b1);
        doReset();
        grant_log.delete();
        ctrl_latency = 1;
        fork
            applyStimulus(0, 1'b0, 16'h0600, 16'h0000);
            applyStimulus(1, 1'b0, 16'h0700, 16'h0000);
        join
        waitDrain();
        checkOutput("t6_first_grant", grant_log[0], 0);
        checkOutput("t6_rdata1", req_rdata[1], rdfun(16'h0700));

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
